// File: rtl/bcd_pkg.sv
// Shared constants and state type for the digit-serial BCD adder.
package bcd_pkg;
   localparam int BCD_W   = 4;
   localparam int BCD_ADJ = 6;
   localparam int BCD_MAX = 9;

   typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
endpackage

// File: rtl/bcd_serial_adder_if.sv
// Operand/result bundle between a requester and the serial BCD adder.
interface bcd_serial_adder_if
   import bcd_pkg::*;
#(parameter int DIGITS = 4) ();
   localparam int DW = BCD_W * DIGITS;

   logic          start;
   logic [DW-1:0] a;
   logic [DW-1:0] b;
   logic          cin;
   logic          busy;
   logic          done;
   logic [DW-1:0] sum;
   logic          cout;
   logic          err;

   modport master (output start, a, b, cin, input busy, done, sum, cout, err);
   modport slave  (input start, a, b, cin, output busy, done, sum, cout, err);
endinterface

// File: rtl/bcd_digit_stage.sv
// One corrected BCD digit adder: binary add, then +6 when the sum passes 9.
module bcd_digit_stage
   import bcd_pkg::*;
(
   input  logic [BCD_W-1:0] x,
   input  logic [BCD_W-1:0] y,
   input  logic             ci,
   output logic [BCD_W-1:0] digit,
   output logic             co,
   output logic             invalid
);
   logic [BCD_W:0] t;

   assign t       = {1'b0, x} + {1'b0, y} + {{BCD_W{1'b0}}, ci};
   assign co      = t > (BCD_W+1)'(BCD_MAX);
   // the correction wraps mod 16, so the carry bit of t+6 is dropped on purpose
   assign digit   = co ? BCD_W'(t + (BCD_W+1)'(BCD_ADJ)) : t[BCD_W-1:0];
   assign invalid = (x > BCD_W'(BCD_MAX)) | (y > BCD_W'(BCD_MAX));
endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial multi-digit BCD adder: one shared digit stage walked LSD first.
module bcd_serial_adder
   import bcd_pkg::*;
#(parameter int DIGITS = 4)
(
   input  logic               clk,
   input  logic               rst,
   bcd_serial_adder_if.slave  bus
);
   localparam int            IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

   state_t                       state, state_nx;
   logic [IW-1:0]                idx;
   logic                         carry;
   logic [DIGITS-1:0][BCD_W-1:0] a_q, b_q, sum_q;
   logic                         cout_q, err_q;
   logic                         accept, last;
   logic [BCD_W-1:0]             dig;
   logic                         dig_co, dig_bad;

   assign last = (idx == LAST);

   bcd_digit_stage u_stage (
      .x       (a_q[idx]),
      .y       (b_q[idx]),
      .ci      (carry),
      .digit   (dig),
      .co      (dig_co),
      .invalid (dig_bad)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      bus.busy = 1'b0;
      bus.done = 1'b0;
      case (state)
         IDLE: begin
            accept = bus.start;
            if (bus.start) state_nx = ADD;
         end
         ADD: begin
            bus.busy = 1'b1;
            if (last) state_nx = DONE;
         end
         DONE: begin
            bus.done = 1'b1;
            accept   = bus.start;
            state_nx = bus.start ? ADD : IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // results are cleared on acceptance so a stale sum never mixes with new digits
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx    <= '0;
         carry  <= 1'b0;
         a_q    <= '0;
         b_q    <= '0;
         sum_q  <= '0;
         cout_q <= 1'b0;
         err_q  <= 1'b0;
      end else if (accept) begin
         a_q    <= bus.a;
         b_q    <= bus.b;
         carry  <= bus.cin;
         idx    <= '0;
         sum_q  <= '0;
         cout_q <= 1'b0;
         err_q  <= 1'b0;
      end else if (state == ADD) begin
         sum_q[idx] <= dig;
         carry      <= dig_co;
         err_q      <= err_q | dig_bad;
         if (last) cout_q <= dig_co;
         else      idx    <= idx + 1'b1;
      end
   end

   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;
   assign bus.err  = err_q;
endmodule

// File: tb/tb_bcd_serial_adder.sv
// Bench for bcd_serial_adder: fixed vectors, multi-cycle corner sequences, random ops vs a decimal model.
module tb_bcd_serial_adder;
   localparam int DIGITS = 4;
   localparam int DW     = 4 * DIGITS;

   logic clk = 1'b0;
   logic rst;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   bcd_serial_adder_if #(.DIGITS(DIGITS)) bus ();
   bcd_serial_adder #(.DIGITS(DIGITS)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      logic [DW-1:0] a, b;
      logic          cin;
      logic [DW-1:0] s;
      logic          co, e;
   } vec_t;

   typedef struct packed {
      logic [DW-1:0] s;
      logic          co;
      logic          e;
   } res_t;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
      end
   endtask

   // Valid operands: plain decimal arithmetic. Invalid digits: the per-digit +6 rule.
   function automatic res_t model(input logic [DW-1:0] x, input logic [DW-1:0] y, input logic c);
      res_t r;
      logic ok;
      int   dx, dy, tot, p, t;
      logic cy;
      r  = '0;
      ok = 1'b1;
      for (int i = 0; i < DIGITS; i++)
         if (x[4*i +: 4] > 4'd9 || y[4*i +: 4] > 4'd9) ok = 1'b0;
      r.e = !ok;
      if (ok) begin
         dx = 0; dy = 0; p = 1;
         for (int i = 0; i < DIGITS; i++) begin
            dx += int'(x[4*i +: 4]) * p;
            dy += int'(y[4*i +: 4]) * p;
            p  *= 10;
         end
         tot  = dx + dy + int'(c);
         r.co = (tot >= p);
         tot  = tot % p;
         for (int i = 0; i < DIGITS; i++) begin
            r.s[4*i +: 4] = 4'(tot % 10);
            tot /= 10;
         end
      end else begin
         cy = c;
         for (int i = 0; i < DIGITS; i++) begin
            t = int'(x[4*i +: 4]) + int'(y[4*i +: 4]) + int'(cy);
            if (t > 9) begin r.s[4*i +: 4] = 4'((t + 6) % 16); cy = 1'b1; end
            else       begin r.s[4*i +: 4] = 4'(t);            cy = 1'b0; end
         end
         r.co = cy;
      end
      return r;
   endfunction

   // One isolated operation: start for one cycle, scramble inputs afterwards, check timing and result.
   task automatic do_op(input logic [DW-1:0] ta, input logic [DW-1:0] tb_b, input logic tc,
                        input logic [DW-1:0] es, input logic ec, input logic ee, input string nm);
      int cyc, bcnt;
      @(negedge clk);
      bus.start = 1'b1; bus.a = ta; bus.b = tb_b; bus.cin = tc;
      @(negedge clk);
      bus.start = 1'b0; bus.a = DW'($urandom); bus.b = DW'($urandom); bus.cin = 1'($urandom);
      cyc = 1; bcnt = 0;
      while (!bus.done && cyc < 20) begin
         if (bus.busy) bcnt++;
         @(negedge clk);
         cyc++;
      end
      chk({nm, " latency"}, 32'(cyc), 32'd5);
      chk({nm, " busy_cycles"}, 32'(bcnt), 32'd4);
      chk({nm, " sum"}, 32'(bus.sum), 32'(es));
      chk({nm, " cout"}, 32'(bus.cout), 32'(ec));
      chk({nm, " err"}, 32'(bus.err), 32'(ee));
      @(negedge clk);
      chk({nm, " done_width"}, {30'd0, bus.done, bus.busy}, 32'd0);
      chk({nm, " sum_hold"}, 32'(bus.sum), 32'(es));
   endtask

   vec_t tbl[8];
   res_t r;
   logic [DW-1:0] ra, rb;
   logic rc;
   int dcnt, idle, dcyc;
   logic [DW-1:0] dsum;

   initial begin
      tbl[0] = '{16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0};
      tbl[1] = '{16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
      tbl[2] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
      tbl[3] = '{16'h00A0, 16'h0000, 1'b0, 16'h0100, 1'b0, 1'b1};
      tbl[4] = '{16'h0005, 16'h0005, 1'b0, 16'h0010, 1'b0, 1'b0};
      tbl[5] = '{16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0};
      tbl[6] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'h5554, 1'b1, 1'b1};
      tbl[7] = '{16'h0909, 16'h0091, 1'b0, 16'h1000, 1'b0, 1'b0};

      rst = 1'b1; bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset busy", 32'(bus.busy), 32'd0);
      chk("reset done", 32'(bus.done), 32'd0);
      chk("reset sum", 32'(bus.sum), 32'd0);
      chk("reset cout_err", {30'd0, bus.cout, bus.err}, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 8; i++)
         do_op(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].s, tbl[i].co, tbl[i].e, $sformatf("tbl%0d", i));

      // start pulsed two cycles into ADD must be ignored
      @(negedge clk);
      bus.start = 1'b1; bus.a = 16'h1234; bus.b = 16'h5678; bus.cin = 1'b0;
      dcnt = 0; dcyc = 0; dsum = '0;
      for (int c = 1; c <= 14; c++) begin
         @(negedge clk);
         bus.start = (c == 2);
         if (c == 2) begin bus.a = 16'h1111; bus.b = 16'h2222; end
         if (bus.done) begin dcnt++; dcyc = c; dsum = bus.sum; end
      end
      chk("ignore done_count", 32'(dcnt), 32'd1);
      chk("ignore done_cycle", 32'(dcyc), 32'd5);
      chk("ignore sum", 32'(dsum), 32'h6912);

      // start held high: back-to-back ops, never idle
      @(negedge clk);
      bus.start = 1'b1; bus.a = 16'h0001; bus.b = 16'h0001; bus.cin = 1'b0;
      dcnt = 0; idle = 0;
      for (int c = 1; c <= 15; c++) begin
         @(negedge clk);
         if (!bus.busy && !bus.done) idle++;
         if (bus.done) begin
            dcnt++;
            chk($sformatf("held sum@%0d", c), 32'(bus.sum), 32'h0002);
            chk($sformatf("held done_cycle@%0d", c), 32'(c % 5), 32'd0);
         end
      end
      bus.start = 1'b0;
      chk("held done_count", 32'(dcnt), 32'd3);
      chk("held idle_cycles", 32'(idle), 32'd0);
      repeat (7) @(negedge clk);

      // asynchronous reset between edges in the middle of ADD
      bus.start = 1'b1; bus.a = 16'h12A4; bus.b = 16'h5678; bus.cin = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (2) @(negedge clk);
      chk("pre_reset err", 32'(bus.err), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("async busy_done", {30'd0, bus.busy, bus.done}, 32'd0);
      chk("async sum", 32'(bus.sum), 32'd0);
      chk("async cout_err", {30'd0, bus.cout, bus.err}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      dcnt = 0;
      repeat (8) begin
         @(negedge clk);
         if (bus.done || bus.busy) dcnt++;
      end
      chk("post_reset activity", 32'(dcnt), 32'd0);
      do_op(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, "post_reset");

      for (int n = 0; n < 30; n++) begin
         if ($urandom_range(0, 3) != 0) begin
            for (int d = 0; d < DIGITS; d++) begin
               ra[4*d +: 4] = 4'($urandom_range(0, 9));
               rb[4*d +: 4] = 4'($urandom_range(0, 9));
            end
         end else begin
            ra = DW'($urandom);
            rb = DW'($urandom);
         end
         rc = 1'($urandom);
         r  = model(ra, rb, rc);
         do_op(ra, rb, rc, r.s, r.co, r.e, $sformatf("rnd%0d", n));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
